// File: rtl/intel_pcie_tlp_pkg.sv
// TLP RX routing helpers: Type field constants, route classes and the SOP classifier.
// Combinational only: no latency, no backpressure.
package intel_pcie_tlp_pkg;

   localparam logic [4:0] TLP_TYPE_MEM   = 5'b00000;
   localparam logic [4:0] TLP_TYPE_MEMLK = 5'b00001;
   localparam logic [4:0] TLP_TYPE_CPL   = 5'b01010;
   localparam logic [4:0] TLP_TYPE_CPLLK = 5'b01011;

   typedef enum logic [1:0] {
      ROUTE_REQ  = 2'd0,
      ROUTE_CPL  = 2'd1,
      ROUTE_DROP = 2'd2
   } route_e;

   // Type sits in the low byte of DW0 after the adapter's DW reordering; Fmt is ignored.
   function automatic route_e tlp_classify(input logic [31:0] dw0);
      route_e r;
      case (dw0[4:0])
         TLP_TYPE_MEM, TLP_TYPE_MEMLK: r = ROUTE_REQ;
         TLP_TYPE_CPL, TLP_TYPE_CPLLK: r = ROUTE_CPL;
         default:                      r = ROUTE_DROP;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/tlp_st_reg_slice.sv
// One-beat Avalon-ST output register: 1-cycle latency; loads only when the router saw ready,
// valid drops when the sink takes the beat.
module tlp_st_reg_slice #(
   parameter int DATA_W  = 256,
   parameter int EMPTY_W = 5
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               i_load,
   input  logic [DATA_W-1:0]  i_data,
   input  logic [EMPTY_W-1:0] i_empty,
   input  logic               i_error,
   input  logic               i_sop,
   input  logic               i_eop,
   input  logic               i_ready,
   output logic [DATA_W-1:0]  o_data,
   output logic [EMPTY_W-1:0] o_empty,
   output logic               o_error,
   output logic               o_sop,
   output logic               o_eop,
   output logic               o_valid
);

   logic [DATA_W-1:0]  r_data;
   logic [EMPTY_W-1:0] r_empty;
   logic               r_error;
   logic               r_sop;
   logic               r_eop;
   logic               r_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data  <= '0;
         r_empty <= '0;
         r_error <= 1'b0;
         r_sop   <= 1'b0;
         r_eop   <= 1'b0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_data;
         r_empty <= i_empty;
         r_error <= i_error;
         r_sop   <= i_sop;
         r_eop   <= i_eop;
         r_valid <= 1'b1;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_data  = r_data;
   assign o_empty = r_empty;
   assign o_error = r_error;
   assign o_sop   = r_sop;
   assign o_eop   = r_eop;
   assign o_valid = r_valid;

endmodule

// File: rtl/intel_pcie_tlp_rx_router.sv
// Steers whole TLPs to req_st (MRd/MWr) or cpl_st (Cpl*), drops the rest; 1-cycle latency, each port
// backpressures only its own traffic. Counters exist only when TLP_RX_ROUTER_STATS_EN is defined.
module intel_pcie_tlp_rx_router
   import intel_pcie_tlp_pkg::*;
#(
   parameter int DATA_W  = 256,
   parameter int EMPTY_W = 5,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [DATA_W-1:0]  in_st_data,
   input  logic [EMPTY_W-1:0] in_st_empty,
   input  logic               in_st_error,
   input  logic               in_st_startofpacket,
   input  logic               in_st_endofpacket,
   input  logic               in_st_valid,
   output logic               in_st_ready,
   output logic [DATA_W-1:0]  req_st_data,
   output logic [EMPTY_W-1:0] req_st_empty,
   output logic               req_st_error,
   output logic               req_st_startofpacket,
   output logic               req_st_endofpacket,
   output logic               req_st_valid,
   input  logic               req_st_ready,
   output logic [DATA_W-1:0]  cpl_st_data,
   output logic [EMPTY_W-1:0] cpl_st_empty,
   output logic               cpl_st_error,
   output logic               cpl_st_startofpacket,
   output logic               cpl_st_endofpacket,
   output logic               cpl_st_valid,
   input  logic               cpl_st_ready,
   output logic [CNT_W-1:0]   stat_drop_count,
   output logic [CNT_W-1:0]   stat_proto_err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_CPL  = 2'd2;
   localparam logic [1:0] ST_DROP = 2'd3;

   logic [1:0] r_state;
   logic [1:0] w_sop_state;
   route_e     w_class;
   route_e     w_tgt;
   logic       w_in_rdy;
   logic       w_acc;
   logic       w_req_load;
   logic       w_cpl_load;

   assign w_class = tlp_classify(in_st_data[DATA_W-1 -: 32]);

   // Non-SOP beats in IDLE have no owner and are swallowed like a dropped packet.
   always_comb begin
      w_tgt = ROUTE_DROP;
      if (in_st_startofpacket) begin
         w_tgt = w_class;
      end else begin
         case (r_state)
            ST_REQ:  w_tgt = ROUTE_REQ;
            ST_CPL:  w_tgt = ROUTE_CPL;
            default: w_tgt = ROUTE_DROP;
         endcase
      end
   end

   always_comb begin
      case (w_tgt)
         ROUTE_REQ: w_in_rdy = ~req_st_valid | req_st_ready;
         ROUTE_CPL: w_in_rdy = ~cpl_st_valid | cpl_st_ready;
         default:   w_in_rdy = 1'b1;
      endcase
   end

   always_comb begin
      case (w_class)
         ROUTE_REQ: w_sop_state = ST_REQ;
         ROUTE_CPL: w_sop_state = ST_CPL;
         default:   w_sop_state = ST_DROP;
      endcase
   end

   assign in_st_ready = w_in_rdy;
   assign w_acc       = in_st_valid & w_in_rdy;
   assign w_req_load  = w_acc & (w_tgt == ROUTE_REQ);
   assign w_cpl_load  = w_acc & (w_tgt == ROUTE_CPL);

   // A SOP always restarts classification, even if the previous packet never saw its EOP.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else if (w_acc) begin
         if (in_st_startofpacket) begin
            r_state <= in_st_endofpacket ? ST_IDLE : w_sop_state;
         end else if (in_st_endofpacket) begin
            r_state <= ST_IDLE;
         end
      end
   end

   tlp_st_reg_slice #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) u_req_slice (
      .clk     (clk),
      .reset_n (reset_n),
      .i_load  (w_req_load),
      .i_data  (in_st_data),
      .i_empty (in_st_empty),
      .i_error (in_st_error),
      .i_sop   (in_st_startofpacket),
      .i_eop   (in_st_endofpacket),
      .i_ready (req_st_ready),
      .o_data  (req_st_data),
      .o_empty (req_st_empty),
      .o_error (req_st_error),
      .o_sop   (req_st_startofpacket),
      .o_eop   (req_st_endofpacket),
      .o_valid (req_st_valid)
   );

   tlp_st_reg_slice #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) u_cpl_slice (
      .clk     (clk),
      .reset_n (reset_n),
      .i_load  (w_cpl_load),
      .i_data  (in_st_data),
      .i_empty (in_st_empty),
      .i_error (in_st_error),
      .i_sop   (in_st_startofpacket),
      .i_eop   (in_st_endofpacket),
      .i_ready (cpl_st_ready),
      .o_data  (cpl_st_data),
      .o_empty (cpl_st_empty),
      .o_error (cpl_st_error),
      .o_sop   (cpl_st_startofpacket),
      .o_eop   (cpl_st_endofpacket),
      .o_valid (cpl_st_valid)
   );

`ifdef TLP_RX_ROUTER_STATS_EN
   logic             w_drop_evt;
   logic             w_proto_evt;
   logic [CNT_W-1:0] r_drop_cnt;
   logic [CNT_W-1:0] r_proto_cnt;

   assign w_drop_evt  = w_acc & in_st_startofpacket & (w_class == ROUTE_DROP);
   assign w_proto_evt = w_acc & ( (in_st_startofpacket  & (r_state != ST_IDLE))
                                | (~in_st_startofpacket & (r_state == ST_IDLE)));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_drop_cnt  <= '0;
         r_proto_cnt <= '0;
      end else begin
         if (w_drop_evt && (r_drop_cnt != {CNT_W{1'b1}}))
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
         if (w_proto_evt && (r_proto_cnt != {CNT_W{1'b1}}))
            r_proto_cnt <= r_proto_cnt + CNT_W'(1);
      end
   end

   assign stat_drop_count = r_drop_cnt;
   assign stat_proto_err  = r_proto_cnt;
`else
   assign stat_drop_count = '0;
   assign stat_proto_err  = '0;
`endif

endmodule

// File: tb/tb_intel_pcie_tlp_rx_router.sv
// Randomized + directed bench for intel_pcie_tlp_rx_router against a packet-level scoreboard.
module tb_intel_pcie_tlp_rx_router;

   localparam int DATA_W  = 256;
   localparam int EMPTY_W = 5;
   localparam int CNT_W   = 32;
`ifdef TLP_RX_ROUTER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   localparam int R_IDLE = 0;
   localparam int R_REQ  = 1;
   localparam int R_CPL  = 2;
   localparam int R_DROP = 3;

   typedef struct packed {
      logic [DATA_W-1:0]  d;
      logic [EMPTY_W-1:0] e;
      logic               err;
      logic               sop;
      logic               eop;
   } beat_t;

   logic               clk = 1'b0;
   logic               reset_n;
   logic [DATA_W-1:0]  in_st_data;
   logic [EMPTY_W-1:0] in_st_empty;
   logic               in_st_error, in_st_startofpacket, in_st_endofpacket, in_st_valid, in_st_ready;
   logic [DATA_W-1:0]  req_st_data, cpl_st_data;
   logic [EMPTY_W-1:0] req_st_empty, cpl_st_empty;
   logic               req_st_error, req_st_startofpacket, req_st_endofpacket, req_st_valid, req_st_ready;
   logic               cpl_st_error, cpl_st_startofpacket, cpl_st_endofpacket, cpl_st_valid, cpl_st_ready;
   logic [CNT_W-1:0]   stat_drop_count, stat_proto_err;

   intel_pcie_tlp_rx_router #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_st_data(in_st_data), .in_st_empty(in_st_empty), .in_st_error(in_st_error),
      .in_st_startofpacket(in_st_startofpacket), .in_st_endofpacket(in_st_endofpacket),
      .in_st_valid(in_st_valid), .in_st_ready(in_st_ready),
      .req_st_data(req_st_data), .req_st_empty(req_st_empty), .req_st_error(req_st_error),
      .req_st_startofpacket(req_st_startofpacket), .req_st_endofpacket(req_st_endofpacket),
      .req_st_valid(req_st_valid), .req_st_ready(req_st_ready),
      .cpl_st_data(cpl_st_data), .cpl_st_empty(cpl_st_empty), .cpl_st_error(cpl_st_error),
      .cpl_st_startofpacket(cpl_st_startofpacket), .cpl_st_endofpacket(cpl_st_endofpacket),
      .cpl_st_valid(cpl_st_valid), .cpl_st_ready(cpl_st_ready),
      .stat_drop_count(stat_drop_count), .stat_proto_err(stat_proto_err)
   );

   always #5 clk = ~clk;

   int n_tot  = 0;
   int n_pass = 0;
   bit rnd_rdy = 1'b0;

   task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
      n_tot++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   // Reference classification straight from the Type field rules.
   function automatic int ref_class(input logic [31:0] dw0);
      int t;
      t = int'(dw0 & 32'h1F);
      if (t == 0 || t == 1)        return R_REQ;
      else if (t == 10 || t == 11) return R_CPL;
      else                         return R_DROP;
   endfunction

   function automatic logic [DATA_W-1:0] rnd_data(input logic [31:0] dw0);
      logic [DATA_W-1:0] d;
      for (int i = 0; i < DATA_W/32; i++) d[i*32 +: 32] = $urandom;
      d[DATA_W-1 -: 32] = dw0;
      return d;
   endfunction

   // ---------------- scoreboard / compare process ----------------
   beat_t q_req[$];
   beat_t q_cpl[$];
   int    m_route = R_IDLE;
   int    m_drop  = 0;
   int    m_proto = 0;
   bit    c_ok = 1'b0, c_acc, c_req_hs, c_cpl_hs;
   int    c_dest;
   beat_t c_beat;

   initial begin
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            q_req.delete(); q_cpl.delete();
            m_route = R_IDLE; m_drop = 0; m_proto = 0; c_ok = 1'b0;
            chk("rst_req_vld", req_st_valid, 0);
            chk("rst_req_side", {req_st_empty, req_st_error, req_st_startofpacket, req_st_endofpacket}, 0);
            chk("rst_req_data", req_st_data, 0);
            chk("rst_cpl_vld", cpl_st_valid, 0);
            chk("rst_cpl_side", {cpl_st_empty, cpl_st_error, cpl_st_startofpacket, cpl_st_endofpacket}, 0);
            chk("rst_cpl_data", cpl_st_data, 0);
            chk("rst_cnt", {stat_drop_count, stat_proto_err}, 0);
         end else begin
            int    dest;
            bit    exp_rdy;
            beat_t f;
            // apply what happened at the edge just passed
            if (c_ok) begin
               if (c_req_hs && q_req.size() != 0) void'(q_req.pop_front());
               if (c_cpl_hs && q_cpl.size() != 0) void'(q_cpl.pop_front());
               if (c_acc) begin
                  if (c_dest == R_REQ) q_req.push_back(c_beat);
                  else if (c_dest == R_CPL) q_cpl.push_back(c_beat);
                  if (c_beat.sop) begin
                     if (m_route != R_IDLE) m_proto++;
                     if (c_dest == R_DROP) m_drop++;
                     m_route = c_beat.eop ? R_IDLE : c_dest;
                  end else if (m_route == R_IDLE) begin
                     m_proto++;
                  end else if (c_beat.eop) begin
                     m_route = R_IDLE;
                  end
               end
            end
            dest = in_st_startofpacket ? ref_class(in_st_data[DATA_W-1 -: 32])
                                       : ((m_route == R_IDLE) ? R_DROP : m_route);
            if (dest == R_DROP)     exp_rdy = 1'b1;
            else if (dest == R_REQ) exp_rdy = (q_req.size() == 0) || req_st_ready;
            else                    exp_rdy = (q_cpl.size() == 0) || cpl_st_ready;
            chk("in_ready", in_st_ready, exp_rdy);
            chk("req_valid", req_st_valid, q_req.size() != 0);
            if (q_req.size() != 0) begin
               f = q_req[0];
               chk("req_data", req_st_data, f.d);
               chk("req_side", {req_st_empty, req_st_error, req_st_startofpacket, req_st_endofpacket},
                   {f.e, f.err, f.sop, f.eop});
            end
            chk("cpl_valid", cpl_st_valid, q_cpl.size() != 0);
            if (q_cpl.size() != 0) begin
               f = q_cpl[0];
               chk("cpl_data", cpl_st_data, f.d);
               chk("cpl_side", {cpl_st_empty, cpl_st_error, cpl_st_startofpacket, cpl_st_endofpacket},
                   {f.e, f.err, f.sop, f.eop});
            end
            chk("drop_count", stat_drop_count, STATS ? m_drop : 0);
            chk("proto_err", stat_proto_err, STATS ? m_proto : 0);
            c_ok     = 1'b1;
            c_acc    = in_st_valid && in_st_ready;
            c_dest   = dest;
            c_beat   = '{d: in_st_data, e: in_st_empty, err: in_st_error,
                         sop: in_st_startofpacket, eop: in_st_endofpacket};
            c_req_hs = req_st_valid && req_st_ready;
            c_cpl_hs = cpl_st_valid && cpl_st_ready;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick_rdy();
      if (rnd_rdy) begin
         req_st_ready = ($urandom_range(0, 3) != 0);
         cpl_st_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   // Called and returns just after a rising edge.
   task automatic send(input logic sop, input logic eop, input logic [DATA_W-1:0] d,
                       input logic [EMPTY_W-1:0] emp, input logic err);
      bit acc = 1'b0;
      in_st_valid = 1'b1; in_st_startofpacket = sop; in_st_endofpacket = eop;
      in_st_data = d; in_st_empty = emp; in_st_error = err;
      for (int k = 0; k < 300 && !acc; k++) begin
         tick_rdy();
         @(negedge clk);
         if (in_st_ready === 1'b1) acc = 1'b1;
         @(posedge clk); #1;
      end
      in_st_valid = 1'b0;
      if (!acc) begin
         n_tot++;
         $display("FAIL send_timeout: in_st_ready stayed 0, expected 1 within 300 cycles");
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin tick_rdy(); @(posedge clk); #1; end
   endtask

   task automatic at_neg();
      @(negedge clk); #1;
   endtask

   task automatic to_edge();
      @(posedge clk); #1;
   endtask

   initial begin
      logic [DATA_W-1:0] d, d4;
      reset_n = 1'b1;
      in_st_valid = 1'b0; in_st_startofpacket = 1'b0; in_st_endofpacket = 1'b0;
      in_st_data = '0; in_st_empty = '0; in_st_error = 1'b0;
      req_st_ready = 1'b1; cpl_st_ready = 1'b1;
      #2 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      idle(2);

      // 1: two-beat MWr to req_st
      d = rnd_data(32'h1234_0040);
      send(1'b1, 1'b0, d, 5'd0, 1'b0);
      at_neg();
      chk("t1_req_vld", req_st_valid, 1);
      chk("t1_req_dw0", req_st_data[255:224], 32'h1234_0040);
      chk("t1_req_sop", req_st_startofpacket, 1);
      chk("t1_cpl_vld", cpl_st_valid, 0);
      to_edge();
      send(1'b0, 1'b1, rnd_data(32'h0), 5'd4, 1'b0);
      at_neg();
      chk("t1_req_eop", {req_st_valid, req_st_endofpacket, req_st_empty}, {2'b11, 5'd4});
      to_edge();

      // 2: single-beat CplD
      send(1'b1, 1'b1, rnd_data(32'h0000_004A), 5'd8, 1'b0);
      at_neg();
      chk("t2_cpl", {cpl_st_valid, cpl_st_startofpacket, cpl_st_endofpacket, cpl_st_empty}, {3'b111, 5'd8});
      chk("t2_cpl_dw0", cpl_st_data[255:224], 32'h0000_004A);
      to_edge();

      // 3: CfgRd dropped while both sinks stall
      req_st_ready = 1'b0; cpl_st_ready = 1'b0;
      send(1'b1, 1'b0, rnd_data(32'h0000_0004), 5'd0, 1'b0);
      send(1'b0, 1'b0, rnd_data(32'h0), 5'd0, 1'b0);
      send(1'b0, 1'b1, rnd_data(32'h0), 5'd0, 1'b0);
      at_neg();
      chk("t3_no_vld", {req_st_valid, cpl_st_valid}, 0);
      chk("t3_drop", stat_drop_count, STATS ? 1 : 0);
      to_edge();

      // 4: stalled REQ does not block a CPL
      cpl_st_ready = 1'b1;
      d4 = rnd_data(32'h0000_0000);
      send(1'b1, 1'b1, d4, 5'd0, 1'b1);
      send(1'b1, 1'b1, rnd_data(32'h0000_004A), 5'd0, 1'b0);
      at_neg();
      chk("t4_cpl_vld", cpl_st_valid, 1);
      chk("t4_req_vld", req_st_valid, 1);
      chk("t4_req_data", req_st_data, d4);
      chk("t4_req_err", req_st_error, 1);
      to_edge();
      req_st_ready = 1'b1;
      idle(2);

      // 5: stray beats in IDLE then MRd
      send(1'b0, 1'b0, rnd_data(32'h0000_0040), 5'd0, 1'b0);
      send(1'b0, 1'b1, rnd_data(32'h0000_0040), 5'd0, 1'b0);
      send(1'b1, 1'b1, rnd_data(32'h0000_0000), 5'd0, 1'b0);
      at_neg();
      chk("t5_req", {req_st_valid, req_st_startofpacket}, 2'b11);
      chk("t5_proto", stat_proto_err, STATS ? 2 : 0);
      to_edge();

      // 6: reset mid-MWr
      send(1'b1, 1'b0, rnd_data(32'h0000_0040), 5'd0, 1'b0);
      reset_n = 1'b0;
      at_neg();
      chk("t6_rst_vld", {req_st_valid, cpl_st_valid}, 0);
      chk("t6_rst_data", req_st_data, 0);
      chk("t6_rst_cnt", {stat_drop_count, stat_proto_err}, 0);
      to_edge();
      reset_n = 1'b1;
      idle(1);
      send(1'b0, 1'b1, rnd_data(32'h0), 5'd0, 1'b0);
      send(1'b1, 1'b1, rnd_data(32'h0000_004A), 5'd0, 1'b0);
      at_neg();
      chk("t6_cpl", {cpl_st_valid, cpl_st_data[255:224]}, {1'b1, 32'h0000_004A});
      chk("t6_req_vld", req_st_valid, 0);
      chk("t6_proto", stat_proto_err, STATS ? 1 : 0);
      to_edge();

      // random traffic with random sink stalls and occasional framing faults
      rnd_rdy = 1'b1;
      for (int p = 0; p < 300; p++) begin
         logic [31:0] dw0;
         logic [7:0]  hdr;
         int          len;
         bit          trunc;
         case ($urandom_range(0, 9))
            0: hdr = 8'h00; 1: hdr = 8'h40; 2: hdr = 8'h01; 3: hdr = 8'h60;
            4: hdr = 8'h0A; 5: hdr = 8'h4A; 6: hdr = 8'h0B; 7: hdr = 8'h04;
            8: hdr = 8'h30; default: hdr = 8'h42;
         endcase
         dw0 = ($urandom & 32'hFFFF_FF00) | {24'h0, hdr};
         len = $urandom_range(1, 4);
         trunc = ($urandom_range(0, 14) == 0);
         if ($urandom_range(0, 14) == 0)
            send(1'b0, 1'($urandom_range(0, 1)), rnd_data($urandom), 5'd0, 1'b0);
         for (int b = 0; b < len; b++) begin
            bit last;
            last = (b == len - 1) && !trunc;
            send(b == 0, last, rnd_data(b == 0 ? dw0 : $urandom),
                 last ? 5'({$urandom_range(0, 7), 2'b00}) : 5'd0, ($urandom_range(0, 7) == 0));
         end
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end

      rnd_rdy = 1'b0;
      req_st_ready = 1'b1; cpl_st_ready = 1'b1;
      idle(4);
      at_neg();
      chk("drain_vld", {req_st_valid, cpl_st_valid}, 0);
      to_edge();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
